// File: rtl/gte_mvmva_seq.sv
// MVMVA micro-sequencer: steps the GTE select path one product per cycle and
// accumulates each matrix row into MAC1..MAC3. Optional macro: GTE_SEQ_FARBUG_EN.
module gte_mvmva_seq #(
  parameter int ACC_W  = 44,
  parameter int PROD_W = 35
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_sf,
  input  logic [1:0]        i_mx,
  input  logic [1:0]        i_v,
  input  logic [1:0]        i_cv,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_isMVMVA,
  output logic [1:0]        o_mx,
  output logic [1:0]        o_vec,
  output logic [3:0]        o_selLeft,
  output logic [3:0]        o_selRight,
  output logic [1:0]        o_row,
  output logic [1:0]        o_comp,
  output logic [1:0]        o_trSel,
  input  logic [31:0]       i_tr,
  input  logic [PROD_W-1:0] i_product,
  output logic              o_macWr,
  output logic [1:0]        o_macIdx,
  output logic [31:0]       o_macVal,
  output logic [2:0]        o_ovfPos,
  output logic [2:0]        o_ovfNeg
);

  localparam int EXT_W = ACC_W + 1;

  typedef enum logic [2:0] {IDLE, INIT, M0, M1, M2, WB, DONE} state_t;

  state_t             state_reg, state_next;
  logic [1:0]         row_reg, row_next;
  logic               sf_reg, sf_next;
  logic [1:0]         mx_reg, mx_next;
  logic [1:0]         v_reg, v_next;
  logic [1:0]         cv_reg, cv_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [2:0]         ovf_pos_reg, ovf_pos_next;
  logic [2:0]         ovf_neg_reg, ovf_neg_next;

  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               is_mvmva_reg, is_mvmva_next;
  logic [3:0]         sel_left_reg, sel_left_next;
  logic [3:0]         sel_right_reg, sel_right_next;
  logic [1:0]         comp_reg, comp_next;
  logic               mac_wr_reg, mac_wr_next;
  logic [1:0]         mac_idx_reg, mac_idx_next;
  logic [31:0]        mac_val_reg, mac_val_next;

  logic [EXT_W-1:0]   tr_ext, acc_ext, prod_ext, sum_ext;
  logic               chk_en, clr_flags, pos_evt, neg_evt;
  logic [2:0]         pos_set, neg_set;

  assign tr_ext   = {{(EXT_W-32){i_tr[31]}}, i_tr} << 12;
  assign acc_ext  = {acc_reg[ACC_W-1], acc_reg};
  assign prod_ext = {{(EXT_W-PROD_W){i_product[PROD_W-1]}}, i_product};

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    sf_next    = sf_reg;
    mx_next    = mx_reg;
    v_next     = v_reg;
    cv_next    = cv_reg;
    acc_next   = acc_reg;
    sum_ext    = acc_ext + prod_ext;
    chk_en     = 1'b0;
    clr_flags  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_start) begin
          sf_next    = i_sf;
          mx_next    = i_mx;
          v_next     = i_v;
          cv_next    = i_cv;
          clr_flags  = 1'b1;
          row_next   = 2'd0;
          state_next = INIT;
        end
      end
      INIT: begin
        sum_ext    = (cv_reg == 2'd3) ? '0 : tr_ext;
        chk_en     = 1'b1;
        acc_next   = sum_ext[ACC_W-1:0];
        state_next = M0;
      end
      M0: begin
        chk_en     = 1'b1;
        acc_next   = sum_ext[ACC_W-1:0];
        state_next = M1;
      end
      M1: begin
        chk_en     = 1'b1;
        acc_next   = sum_ext[ACC_W-1:0];
        state_next = M2;
      end
      M2: begin
        chk_en     = 1'b1;
        acc_next   = sum_ext[ACC_W-1:0];
`ifdef GTE_SEQ_FARBUG_EN
        // Far-colour quirk: the last product overwrites the row instead of adding.
        if (cv_reg == 2'd2) begin
          chk_en   = 1'b0;
          acc_next = prod_ext[ACC_W-1:0];
        end
`endif
        state_next = WB;
      end
      WB: begin
        if (row_reg == 2'd2) begin
          state_next = DONE;
        end else begin
          row_next   = row_reg + 2'd1;
          state_next = INIT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    pos_evt = chk_en && (sum_ext[EXT_W-1:EXT_W-2] == 2'b01);
    neg_evt = chk_en && (sum_ext[EXT_W-1:EXT_W-2] == 2'b10);

    // Output registers are loaded from the state being entered.
    busy_next      = (state_next != IDLE);
    done_next      = (state_next == DONE);
    is_mvmva_next  = 1'b0;
    sel_left_next  = 4'd7;
    sel_right_next = 4'd4;
    comp_next      = 2'd0;
    mac_wr_next    = 1'b0;
    mac_idx_next   = mac_idx_reg;
    mac_val_next   = mac_val_reg;
    case (state_next)
      M0, M1, M2: begin
        is_mvmva_next  = 1'b1;
        sel_right_next = 4'd0;
        comp_next      = (state_next == M0) ? 2'd0 : (state_next == M1) ? 2'd1 : 2'd2;
        sel_left_next  = {2'b00, comp_next};
      end
      WB: begin
        mac_wr_next  = 1'b1;
        mac_idx_next = row_next;
        mac_val_next = sf_next ? acc_next[12 +: 32] : acc_next[31:0];
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flags
      assign pos_set[gi]      = pos_evt && (row_reg == 2'(gi));
      assign neg_set[gi]      = neg_evt && (row_reg == 2'(gi));
      assign ovf_pos_next[gi] = clr_flags ? 1'b0 : (ovf_pos_reg[gi] | pos_set[gi]);
      assign ovf_neg_next[gi] = clr_flags ? 1'b0 : (ovf_neg_reg[gi] | neg_set[gi]);
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      row_reg       <= 2'd0;
      sf_reg        <= 1'b0;
      mx_reg        <= 2'd0;
      v_reg         <= 2'd0;
      cv_reg        <= 2'd0;
      acc_reg       <= '0;
      ovf_pos_reg   <= 3'd0;
      ovf_neg_reg   <= 3'd0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      is_mvmva_reg  <= 1'b0;
      sel_left_reg  <= 4'd7;
      sel_right_reg <= 4'd4;
      comp_reg      <= 2'd0;
      mac_wr_reg    <= 1'b0;
      mac_idx_reg   <= 2'd0;
      mac_val_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      sf_reg        <= sf_next;
      mx_reg        <= mx_next;
      v_reg         <= v_next;
      cv_reg        <= cv_next;
      acc_reg       <= acc_next;
      ovf_pos_reg   <= ovf_pos_next;
      ovf_neg_reg   <= ovf_neg_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      is_mvmva_reg  <= is_mvmva_next;
      sel_left_reg  <= sel_left_next;
      sel_right_reg <= sel_right_next;
      comp_reg      <= comp_next;
      mac_wr_reg    <= mac_wr_next;
      mac_idx_reg   <= mac_idx_next;
      mac_val_reg   <= mac_val_next;
    end
  end

  assign o_busy     = busy_reg;
  assign o_done     = done_reg;
  assign o_isMVMVA  = is_mvmva_reg;
  assign o_mx       = mx_reg;
  assign o_vec      = v_reg;
  assign o_selLeft  = sel_left_reg;
  assign o_selRight = sel_right_reg;
  assign o_row      = row_reg;
  assign o_comp     = comp_reg;
  assign o_trSel    = cv_reg;
  assign o_macWr    = mac_wr_reg;
  assign o_macIdx   = mac_idx_reg;
  assign o_macVal   = mac_val_reg;
  assign o_ovfPos   = ovf_pos_reg;
  assign o_ovfNeg   = ovf_neg_reg;

endmodule
